// File: rtl/xbar_pkg.sv
// Shared crossbar constants and the packet type used by the transmitter, crossbar and receiver.
// Latency: none (declarations only).
// Backpressure: not applicable.
package xbar_pkg;

  localparam int ports        = 8;
  localparam int packet_width = 8;
  // Start bit + data bits + stop bit.
  localparam int frame_len    = packet_width + 2;

  typedef logic [packet_width-1:0] packet;

endpackage

// File: rtl/rx_lane.sv
// One deserializer lane: builds a 10-sample window and checks its start/stop bits on the clk10 strobe.
// Latency: data/valid/frame_err register on the strobe edge that samples the stop bit.
// Backpressure: none; the consumer must take valid when it pulses.
module rx_lane
  import xbar_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clk10,
  input  logic  serial_in,
  output packet data,
  output logic  valid,
  output logic  frame_err
);

  // The previous frame_len-1 samples, newest at the top. Together with the live
  // sample they form the 10-bit frame evaluated on the strobe edge, so the stop
  // bit can be checked on the same edge that samples it.
  logic [frame_len-2:0] hist;
  logic [frame_len-1:0] frame;
  logic                 good;

  // frame[0] is the oldest sample (start bit), frame[frame_len-1] the live one (stop bit).
  assign frame = {serial_in, hist};
  assign good  = ~frame[0] & frame[frame_len-1];

  // Shift every edge; on the strobe accept a well-framed byte or flag the error.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '1;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      hist  <= frame[frame_len-1:1];
      valid <= 1'b0;
      if (clk10) begin
        if (good) begin
          data      <= frame[packet_width:1];
          valid     <= 1'b1;
          frame_err <= 1'b0;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/xbar_receiver.sv
// Receive block for the crossbar: one independent rx_lane per serial output port.
// Latency: one clk from the stop-bit strobe edge to visible data/valid.
// Backpressure: none; each lane pulses valid once per good frame.
module xbar_receiver
  import xbar_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clk10,
  input  logic [ports-1:0]   serial_in,
  output packet [ports-1:0]  data,
  output logic [ports-1:0]   valid,
  output logic [ports-1:0]   frame_err
);

  for (genvar i = 0; i < ports; i++) begin : g_lane
    rx_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .clk10     (clk10),
      .serial_in (serial_in[i]),
      .data      (data[i]),
      .valid     (valid[i]),
      .frame_err (frame_err[i])
    );
  end

endmodule

// File: tb/tb_xbar_receiver.sv
// Self-checking bench for xbar_receiver: directed frame table, hand sequences, random stimulus vs model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_xbar_receiver;
  import xbar_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    clk10 = 1'b0;
  logic [7:0]              serial_in = 8'hFF;
  packet [7:0]             data;
  logic [7:0]              valid;
  logic [7:0]              frame_err;

  xbar_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .clk10     (clk10),
    .serial_in (serial_in),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the raw per-cycle sample words of the last 10 edges, oldest first.
  logic [7:0]      hist[$];
  logic [7:0][7:0] m_data;
  logic [7:0]      m_valid;
  logic [7:0]      m_err;

  typedef struct {
    int         lane;
    logic [7:0] val;
    logic       start;
    logic       stop;
    logic [7:0] exp_data;
    logic [7:0] exp_valid;
    logic [7:0] exp_err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [7:0] tmp;
    logic [7:0] byte_v;
    if (rst) begin
      hist.delete();
      repeat (10) hist.push_back(8'hFF);
      m_data  = '0;
      m_valid = '0;
      m_err   = '0;
    end else begin
      hist.push_back(serial_in);
      tmp = hist.pop_front();
      m_valid = '0;
      if (clk10) begin
        for (int i = 0; i < 8; i++) begin
          if (hist[0][i] == 1'b0 && hist[9][i] == 1'b1) begin
            byte_v = '0;
            for (int b = 0; b < 8; b++) byte_v[b] = hist[b+1][i];
            m_data[i]  = byte_v;
            m_valid[i] = 1'b1;
            m_err[i]   = 1'b0;
          end else begin
            m_err[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_data", data, m_data);
    chk("model_valid", {56'd0, valid}, {56'd0, m_valid});
    chk("model_err", {56'd0, frame_err}, {56'd0, m_err});
  endtask

  task automatic frame_cycle(input int k, input logic [7:0] mask, input logic [7:0][7:0] bytes,
                             input logic [7:0] start_b, input logic [7:0] stop_b);
    for (int i = 0; i < 8; i++) begin
      if (!mask[i])    serial_in[i] = 1'b1;
      else if (k == 0) serial_in[i] = start_b[i];
      else if (k == 9) serial_in[i] = stop_b[i];
      else             serial_in[i] = bytes[i][k-1];
    end
    clk10 = (k == 9);
    tick();
  endtask

  task automatic send_frame(input logic [7:0] mask, input logic [7:0][7:0] bytes,
                            input logic [7:0] start_b, input logic [7:0] stop_b);
    for (int k = 0; k < 10; k++) frame_cycle(k, mask, bytes, start_b, stop_b);
  endtask

  task automatic idle_tick();
    serial_in = 8'hFF;
    clk10     = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0][7:0] bytes;

    tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 8'h01, 8'hFE};
    tbl[1] = '{2, 8'h5A, 1'b0, 1'b1, 8'h5A, 8'h04, 8'hFB};
    tbl[2] = '{2, 8'h77, 1'b0, 1'b0, 8'h5A, 8'h00, 8'hFF};
    tbl[3] = '{2, 8'h3C, 1'b0, 1'b1, 8'h3C, 8'h04, 8'hFB};
    tbl[4] = '{7, 8'h11, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF};
    tbl[5] = '{5, 8'hFF, 1'b0, 1'b1, 8'hFF, 8'h20, 8'hDF};
    tbl[6] = '{6, 8'h00, 1'b0, 1'b1, 8'h00, 8'h40, 8'hBF};
    tbl[7] = '{6, 8'h81, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF};
    tbl[8] = '{4, 8'hE7, 1'b0, 1'b1, 8'hE7, 8'h10, 8'hEF};

    // Reset for 3 cycles on an idle line, with a strobe in the middle.
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      serial_in = 8'hFF;
      clk10     = (c == 1);
      tick();
      chk("rst_data", data, 64'd0);
      chk("rst_valid", {56'd0, valid}, 64'd0);
      chk("rst_err", {56'd0, frame_err}, 64'd0);
    end
    rst   = 1'b0;
    clk10 = 1'b0;

    // Single-lane frames; all other lanes idle and so flag a missing start bit.
    for (int t = 0; t < 9; t++) begin
      for (int i = 0; i < 8; i++) bytes[i] = tbl[t].val;
      send_frame(8'(1 << tbl[t].lane), bytes, {8{tbl[t].start}}, {8{tbl[t].stop}});
      chk($sformatf("tbl%0d_data", t), {56'd0, data[tbl[t].lane]}, {56'd0, tbl[t].exp_data});
      chk($sformatf("tbl%0d_valid", t), {56'd0, valid}, {56'd0, tbl[t].exp_valid});
      chk($sformatf("tbl%0d_err", t), {56'd0, frame_err}, {56'd0, tbl[t].exp_err});
    end

    // Every lane at once with a distinct byte.
    for (int i = 0; i < 8; i++) bytes[i] = 8'h10 + 8'(i);
    send_frame(8'hFF, bytes, 8'h00, 8'hFF);
    chk("all_valid", {56'd0, valid}, 64'hFF);
    chk("all_err", {56'd0, frame_err}, 64'h00);
    for (int i = 0; i < 8; i++)
      chk($sformatf("all_data%0d", i), {56'd0, data[i]}, {56'd0, 8'h10 + 8'(i)});

    // Header then payload back to back on lane 3; each byte must hold for the whole period.
    for (int i = 0; i < 8; i++) bytes[i] = 8'h03;
    send_frame(8'h08, bytes, 8'h00, 8'hFF);
    chk("hdr_data", {56'd0, data[3]}, 64'h03);
    chk("hdr_valid", {56'd0, valid}, 64'h08);
    for (int i = 0; i < 8; i++) bytes[i] = 8'h5C;
    for (int k = 0; k < 9; k++) begin
      frame_cycle(k, 8'h08, bytes, 8'h00, 8'hFF);
      chk("hdr_hold", {56'd0, data[3]}, 64'h03);
      chk("hdr_novalid", {56'd0, valid}, 64'h00);
    end
    frame_cycle(9, 8'h08, bytes, 8'h00, 8'hFF);
    chk("pay_data", {56'd0, data[3]}, 64'h5C);
    chk("pay_valid", {56'd0, valid}, 64'h08);
    for (int k = 0; k < 9; k++) begin
      idle_tick();
      chk("pay_hold", {56'd0, data[3]}, 64'h5C);
    end

    // Reset after 5 bits of a frame, then a complete frame on the same lane.
    for (int i = 0; i < 8; i++) bytes[i] = 8'hC3;
    for (int k = 0; k < 5; k++) frame_cycle(k, 8'h02, bytes, 8'h00, 8'hFF);
    rst       = 1'b1;
    serial_in = 8'hFF;
    clk10     = 1'b0;
    tick();
    chk("midrst_data", data, 64'd0);
    chk("midrst_valid", {56'd0, valid}, 64'd0);
    chk("midrst_err", {56'd0, frame_err}, 64'd0);
    rst = 1'b0;
    send_frame(8'h02, bytes, 8'h00, 8'hFF);
    chk("postrst_data", {56'd0, data[1]}, 64'hC3);
    chk("postrst_valid", {56'd0, valid}, 64'h02);
    chk("postrst_err", {56'd0, frame_err}, 64'hFD);

    // Random lines, strobes (including consecutive ones) and occasional resets.
    for (int c = 0; c < 500; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      clk10     = ($urandom_range(0, 3) == 0);
      serial_in = 8'($urandom);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xbar_receiver.md
# xbar_receiver

Serial-to-parallel receive block for the 8×8 crossbar datapath. It has one deserializer lane per crossbar output port. Each lane samples its serial line every clock and assembles one 10-bit frame per `clk10` period. On each frame boundary it presents the recovered 8-bit `packet` on `data`. It sits downstream of the second crossbar's `serial_out` and feeds the transactor that alternately collects header and payload bytes.

## Interface
Parameters:
- `ports`, 8: number of serial lanes (from `xbar_pkg`).
- `packet_width`, 8: data bits per frame (from `xbar_pkg`).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clk10`  in  1  frame strobe from the crossbar; high for one `clk` cycle every 10 cycles; marks the edge that samples the last bit of a frame.
- `serial_in`  in  `ports`  one serial line per lane; idle level 1.
- `data`  out  `packet [ports-1:0]`  last good byte per lane.
- `valid`  out  `ports`  one-cycle pulse per lane when that lane's `data` updates.
- `frame_err`  out  `ports`  per lane, set when the last completed frame was malformed.

## Operation
- Frame format, first bit first: bit 0 = start (0), bits 1..8 = data LSB first, bit 9 = stop (1). Frame length is `packet_width`+2 = 10.
- Each lane shifts `serial_in[i]` into a 10-bit register on every edge, newest bit at the top. Frame bit f[0] is therefore the oldest sample.
- The frame f[9:0] is the 10 samples ending with, and including, the sample taken on the edge where `clk10`=1.
- On that edge, per lane:
  - Good frame (f[0]==0 and f[9]==1): `data[i]` <= f[8:1], `valid[i]` <= 1, `frame_err[i]` <= 0.
  - Bad frame: `data[i]` holds its previous value, `valid[i]` <= 0, `frame_err[i]` <= 1.
- All lanes are independent. A bad frame on one lane does not affect the others.
- `valid` is 0 on every edge where `clk10`=0.
- `frame_err` holds its value until the next `clk10` edge.
- The block has no header/payload awareness. The consumer decides which byte is which.

## Timing
- Reset (`rst`=1 at an edge, which has priority over `clk10`):
  - shift registers <= all 1s (idle).
  - `data` <= 0.
  - `valid` <= 0.
  - `frame_err` <= 0.
- Latency: `data`/`valid` update on the same edge that samples the stop bit; visible in the following cycle.
- `data` is stable for the full 10-cycle period between strobes, so a consumer sampling on the next `clk10` edge sees the previous frame.
- Reset mid-frame discards the partial frame. The first `clk10` after reset release validates only if a proper start bit falls in the window.
- `clk10` asserted on consecutive cycles: each assertion evaluates the current 10-sample window (no special handling).
- Idle line (all 1s) at a strobe yields `frame_err`=1 because the start bit is missing.

## Structure
- `xbar_pkg` holds `ports`, `packet_width`, and `typedef logic [packet_width-1:0] packet`. This package is shared with the transmitter and the crossbar.
- One sub-module, `rx_lane`, contains:
  - inputs: `clk`, `rst`, `clk10`, `serial_in` (1 bit);
  - outputs: `data` (packet), `valid`, `frame_err`;
  - a 10-bit shift register and the frame check.
- The top level instantiates `rx_lane` `ports` times with a generate loop.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `serial_in`=8'hFF:
  - `data`=0, `valid`=0, `frame_err`=0 on every lane.
  - Also assert `clk10` during reset → outputs stay 0.
- Single frame:
  - Drive lane 0 with start 0, bits of 8'hA5 LSB first, stop 1, aligned so the stop bit coincides with `clk10`.
  - Expect `data[0]`=8'hA5 and a one-cycle `valid[0]`; other lanes show `frame_err`=1 (idle).
- All lanes: drive lane i with byte 8'h10+i.
  - After the strobe, `data[i]`=8'h10+i for all 8 lanes and `valid`=8'hFF.
- Back-to-back header/payload on lane 3, 8'h03 then 8'h5C over 20 cycles:
  - `data[3]`=8'h03 after the first strobe and 8'h5C after the second.
  - Each value holds 10 cycles.
- Framing error:
  - Send 8'h77 on lane 2 with stop bit 0 → `frame_err[2]`=1, `valid[2]`=0, `data[2]` keeps its prior value.
  - The next good frame clears `frame_err[2]`.
- Reset mid-frame: assert `rst` after 5 bits of a frame.
  - Outputs return to 0.
  - A following complete frame of 8'hC3 → `data`=8'hC3.
